idu_stage: RTL and testbench
============================

IDU_STAGE -- requirements
Module: idu_stage

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width (32 or 64 only).
REQ-002 SHALL have parameter RV64W_EN, default 1, decode OP-IMM-32/OP-32 (forced to 0 when XLEN=32).
REQ-003 Clocking: one clock; reset is synchronous and active-low.
REQ-004 clock  in  1  stage clock.
REQ-005 reset  in  1  synchronous reset, asserted at 0.
REQ-006 flush  in  1  kill held entry and block acceptance this cycle.
REQ-007 in_valid  in  1  fetch offers instruction.
REQ-008 in_ready  out  1  stage accepts this cycle.
REQ-009 in_pc  in  XLEN  instruction address.
REQ-010 in_inst  in  32  instruction word.
REQ-011 out_valid  out  1  decoded entry held.
REQ-012 out_ready  in  1  execute consumes entry.
REQ-013 out_pc / out_inst  out  XLEN / 32  registered copies.
REQ-014 out_rs1, out_rs2, out_rd  out  5 each  inst[19:15], [24:20], [11:7].
REQ-015 out_imm  out  XLEN  sign-extended immediate.
REQ-016 out_fmt  out  3  format code: R, I, S, B, U, J, N.
REQ-017 out_reg_write, out_src1_is_pc, out_src2_is_imm, out_mem_read, out_mem_write, out_branch, out_jump, out_illegal  out  1 each  control bits.
REQ-018 halted  out  1  EBREAK retired through stage.

Function
REQ-019 in_ready SHALL equal !halted && !flush && (!out_valid || out_ready).
REQ-020 Transfer when in_valid && in_ready; the decoded entry SHALL appear on outputs the next cycle with out_valid=1 (latency 1).
REQ-021 With out_valid && !out_ready, all out_* SHALL hold stable; no input accepted.
REQ-022 Simultaneous consume and accept SHALL replace the entry with no bubble (full throughput).
REQ-023 flush=1 SHALL clear out_valid next cycle, overriding any transfer; halted is unaffected.
REQ-024 Decode set: LUI, AUIPC (U); JAL (J); JALR, LOAD, OP-IMM (I); BRANCH (B); STORE (S); OP (R); OP-IMM-32 (I) and OP-32 (R) only when RV64W_EN; EBREAK 0x00100073 (N).
REQ-025 Imm: I = inst[31:20]; S = {inst[31:25], inst[11:7]}; B = {inst[31], inst[7], inst[30:25], inst[11:8], 0}; U = {inst[31:12], 12'h0}; J = {inst[31], inst[19:12], inst[20], inst[30:21], 0}; all sign-extended to XLEN; R/N = 0.
REQ-026 reg_write=1 for U, J, I-formats; R-format; 0 for S, B, EBREAK, illegal.
REQ-027 src1_is_pc=1 for AUIPC, JAL; src2_is_imm=1 for I, S, U, J; mem_read=LOAD; mem_write=STORE; branch=BRANCH; jump=JAL|JALR.
REQ-028 Any unlisted encoding SHALL set out_illegal=1, out_fmt=N, all other control bits 0.
REQ-029 FSM: RUN -> HALT when an EBREAK entry is consumed (out_valid && out_ready); HALT exits only by reset.
REQ-030 halted=1 in HALT; in_ready=0 in HALT.

Reset
REQ-031 On reset=0 at a clock edge: state RUN, out_valid=0, halted=0, all out_* data/control = 0, out_fmt=N.
REQ-032 Reset mid-operation SHALL discard the held entry without asserting any control bit.

Structure
REQ-033 Package idu_pkg SHALL hold format enum, opcode constants, EBREAK constant, control-bundle typedef.
REQ-034 Immediate generation SHALL be sub-module imm_gen (inputs inst, fmt; output XLEN imm); decode combinational, single pipeline register.

Verification
REQ-035 0xFFF00093 (addi x1,x0,-1) -> next cycle out_imm all ones, rd=1, reg_write=1, src2_is_imm=1, fmt=I.
REQ-036 0x0020B423 (sd x2,8(x1)) -> imm=8, rs1=1, rs2=2, mem_write=1, reg_write=0, fmt=S.
REQ-037 0xFE000CE3 (beq x0,x0,-8) -> imm=-8, branch=1, reg_write=0; out_ready=0 for 3 cycles with next in_valid -> outputs stable, in_ready=0, then accepted without loss.
REQ-038 0x00100073 consumed -> halted=1 next cycle, in_ready=0 thereafter; flush does not clear; reset=0 clears.
REQ-039 flush with in_valid=1 -> in_ready=0, out_valid=0 next cycle.
REQ-040 XLEN=32: 0x800000B7 (lui x1) -> imm=0x80000000; 0x0000001B (addiw) -> illegal=1.

Source files
------------

// File: rtl/idu_pkg.sv
// Shared decode definitions for the instruction-decode stage: format codes,
// opcode constants, the EBREAK encoding, the control bundle and the decoder.
package idu_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5,
    FMT_N = 3'd6
  } fmt_e;

  localparam logic [6:0] OPC_LUI        = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC      = 7'b0010111;
  localparam logic [6:0] OPC_JAL        = 7'b1101111;
  localparam logic [6:0] OPC_JALR       = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH     = 7'b1100011;
  localparam logic [6:0] OPC_LOAD       = 7'b0000011;
  localparam logic [6:0] OPC_STORE      = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM     = 7'b0010011;
  localparam logic [6:0] OPC_OP         = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM_32  = 7'b0011011;
  localparam logic [6:0] OPC_OP_32      = 7'b0111011;

  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  typedef struct packed {
    logic reg_write;
    logic src1_is_pc;
    logic src2_is_imm;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jump;
    logic illegal;
  } ctrl_t;

  typedef struct packed {
    fmt_e  fmt;
    ctrl_t ctrl;
  } dec_t;

  // Opcode-level decode; anything not recognised (including every SYSTEM
  // word other than EBREAK) becomes an illegal N-format entry.
  function automatic dec_t decode(input logic [31:0] inst, input logic w_en);
    dec_t d;
    d.fmt  = FMT_N;
    d.ctrl = '0;
    case (inst[6:0])
      OPC_LUI: begin
        d.fmt = FMT_U; d.ctrl.reg_write = 1'b1; d.ctrl.src2_is_imm = 1'b1;
      end
      OPC_AUIPC: begin
        d.fmt = FMT_U; d.ctrl.reg_write = 1'b1; d.ctrl.src2_is_imm = 1'b1;
        d.ctrl.src1_is_pc = 1'b1;
      end
      OPC_JAL: begin
        d.fmt = FMT_J; d.ctrl.reg_write = 1'b1; d.ctrl.src2_is_imm = 1'b1;
        d.ctrl.src1_is_pc = 1'b1; d.ctrl.jump = 1'b1;
      end
      OPC_JALR: begin
        d.fmt = FMT_I; d.ctrl.reg_write = 1'b1; d.ctrl.src2_is_imm = 1'b1;
        d.ctrl.jump = 1'b1;
      end
      OPC_LOAD: begin
        d.fmt = FMT_I; d.ctrl.reg_write = 1'b1; d.ctrl.src2_is_imm = 1'b1;
        d.ctrl.mem_read = 1'b1;
      end
      OPC_OP_IMM: begin
        d.fmt = FMT_I; d.ctrl.reg_write = 1'b1; d.ctrl.src2_is_imm = 1'b1;
      end
      OPC_BRANCH: begin
        d.fmt = FMT_B; d.ctrl.branch = 1'b1;
      end
      OPC_STORE: begin
        d.fmt = FMT_S; d.ctrl.src2_is_imm = 1'b1; d.ctrl.mem_write = 1'b1;
      end
      OPC_OP: begin
        d.fmt = FMT_R; d.ctrl.reg_write = 1'b1;
      end
      OPC_OP_IMM_32: begin
        if (w_en) begin
          d.fmt = FMT_I; d.ctrl.reg_write = 1'b1; d.ctrl.src2_is_imm = 1'b1;
        end else begin
          d.ctrl.illegal = 1'b1;
        end
      end
      OPC_OP_32: begin
        if (w_en) begin
          d.fmt = FMT_R; d.ctrl.reg_write = 1'b1;
        end else begin
          d.ctrl.illegal = 1'b1;
        end
      end
      default: begin
        if (inst != INST_EBREAK) d.ctrl.illegal = 1'b1;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/idu_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// master: fetch/execute environment; slave: the decode stage.
interface idu_if import idu_pkg::*; #(
  parameter int unsigned XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [31:0]     in_inst;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_inst;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic [XLEN-1:0] out_imm;
  fmt_e            out_fmt;
  logic            out_reg_write;
  logic            out_src1_is_pc;
  logic            out_src2_is_imm;
  logic            out_mem_read;
  logic            out_mem_write;
  logic            out_branch;
  logic            out_jump;
  logic            out_illegal;

  modport master (
    output in_valid, in_pc, in_inst, out_ready,
    input  in_ready, out_valid, out_pc, out_inst, out_rs1, out_rs2, out_rd,
           out_imm, out_fmt, out_reg_write, out_src1_is_pc, out_src2_is_imm,
           out_mem_read, out_mem_write, out_branch, out_jump, out_illegal
  );

  modport slave (
    input  in_valid, in_pc, in_inst, out_ready,
    output in_ready, out_valid, out_pc, out_inst, out_rs1, out_rs2, out_rd,
           out_imm, out_fmt, out_reg_write, out_src1_is_pc, out_src2_is_imm,
           out_mem_read, out_mem_write, out_branch, out_jump, out_illegal
  );
endinterface

// File: rtl/imm_gen.sv
// Immediate generator: assembles the format-specific immediate and
// sign-extends it to XLEN. Ports: inst (word), fmt (format), imm (result).
module imm_gen import idu_pkg::*; #(
  parameter int unsigned XLEN = 64
) (
  input  logic [31:0]     inst,
  input  fmt_e            fmt,
  output logic [XLEN-1:0] imm
);
  logic signed [31:0] raw;

  // Build a signed 32-bit immediate, then widen with sign extension.
  always_comb begin
    raw = '0;
    case (fmt)
      FMT_I: raw = 32'($signed(inst[31:20]));
      FMT_S: raw = 32'($signed({inst[31:25], inst[11:7]}));
      FMT_B: raw = 32'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
      FMT_U: raw = $signed({inst[31:12], 12'h000});
      FMT_J: raw = 32'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
      default: raw = '0;
    endcase
    imm = XLEN'(raw);
  end
endmodule

// File: rtl/idu_stage.sv
// Instruction-decode pipeline stage: combinational decode into a single
// output register with valid/ready handshake, flush, and an EBREAK halt.
// Ports: clock, reset (sync, active-low), flush, halted, bus (idu_if.slave).
module idu_stage import idu_pkg::*; #(
  parameter int unsigned XLEN     = 64,
  parameter bit          RV64W_EN = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic flush,
  output logic halted,
  idu_if.slave bus
);
  // W-suffixed opcodes exist only on a 64-bit datapath.
  localparam bit W_EN = (XLEN == 32'd64) && RV64W_EN;

  typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_e;

  state_e          state_q, state_d;
  logic            halted_q;
  logic            valid_q;
  logic [XLEN-1:0] pc_q, imm_q;
  logic [31:0]     inst_q;
  fmt_e            fmt_q;
  ctrl_t           ctrl_q;

  dec_t            dec;
  logic [XLEN-1:0] imm_d;
  logic            accept, consume;

  assign dec = decode(bus.in_inst, W_EN);

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .inst (bus.in_inst),
    .fmt  (dec.fmt),
    .imm  (imm_d)
  );

  assign bus.in_ready = !halted_q && !flush && (!valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign consume      = valid_q && bus.out_ready;

  // Halt once a held EBREAK (legal N-format) is handed to execute.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (consume && (fmt_q == FMT_N) && !ctrl_q.illegal) state_d = S_HALT;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= S_RUN;
      halted_q <= 1'b0;
      valid_q  <= 1'b0;
      pc_q     <= '0;
      inst_q   <= '0;
      imm_q    <= '0;
      fmt_q    <= FMT_N;
      ctrl_q   <= '0;
    end else begin
      state_q  <= state_d;
      halted_q <= (state_d == S_HALT);
      // accept already excludes flush, so flush always empties the register
      if (flush)        valid_q <= 1'b0;
      else if (accept)  valid_q <= 1'b1;
      else if (consume) valid_q <= 1'b0;
      if (accept) begin
        pc_q   <= bus.in_pc;
        inst_q <= bus.in_inst;
        imm_q  <= imm_d;
        fmt_q  <= dec.fmt;
        ctrl_q <= dec.ctrl;
      end
    end
  end

  assign halted              = halted_q;
  assign bus.out_valid       = valid_q;
  assign bus.out_pc          = pc_q;
  assign bus.out_inst        = inst_q;
  assign bus.out_rs1         = inst_q[19:15];
  assign bus.out_rs2         = inst_q[24:20];
  assign bus.out_rd          = inst_q[11:7];
  assign bus.out_imm         = imm_q;
  assign bus.out_fmt         = fmt_q;
  assign bus.out_reg_write   = ctrl_q.reg_write;
  assign bus.out_src1_is_pc  = ctrl_q.src1_is_pc;
  assign bus.out_src2_is_imm = ctrl_q.src2_is_imm;
  assign bus.out_mem_read    = ctrl_q.mem_read;
  assign bus.out_mem_write   = ctrl_q.mem_write;
  assign bus.out_branch      = ctrl_q.branch;
  assign bus.out_jump        = ctrl_q.jump;
  assign bus.out_illegal     = ctrl_q.illegal;
endmodule

// File: tb/tb_idu_stage.sv
// Directed bench for idu_stage: a 64-bit instance exercises handshake,
// decode, flush, reset and halt; a 32-bit instance covers XLEN=32 decode.
module tb_idu_stage;
  import idu_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;
  logic halted64, halted32;
  int   checks = 0;
  int   errors = 0;

  idu_if #(.XLEN(64)) bus64 ();
  idu_if #(.XLEN(32)) bus32 ();

  idu_stage #(.XLEN(64), .RV64W_EN(1'b1)) dut64 (
    .clock(clock), .reset(reset), .flush(flush), .halted(halted64), .bus(bus64)
  );
  idu_stage #(.XLEN(32), .RV64W_EN(1'b1)) dut32 (
    .clock(clock), .reset(reset), .flush(flush), .halted(halted32), .bus(bus32)
  );

  always #5 clock = ~clock;

  // control bits packed as {reg_write, src1_is_pc, src2_is_imm, mem_read,
  //                         mem_write, branch, jump, illegal}
  logic [7:0] ctl64, ctl32;
  assign ctl64 = {bus64.out_reg_write, bus64.out_src1_is_pc, bus64.out_src2_is_imm,
                  bus64.out_mem_read, bus64.out_mem_write, bus64.out_branch,
                  bus64.out_jump, bus64.out_illegal};
  assign ctl32 = {bus32.out_reg_write, bus32.out_src1_is_pc, bus32.out_src2_is_imm,
                  bus32.out_mem_read, bus32.out_mem_write, bus32.out_branch,
                  bus32.out_jump, bus32.out_illegal};

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    checks++; if (bus64.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus64.out_valid); end
    checks++; if (halted64 !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", halted64); end
    checks++; if (bus64.out_fmt !== FMT_N) begin errors++; $display("FAIL reset_fmt got %0d exp %0d", bus64.out_fmt, FMT_N); end
    checks++; if ({ctl64, bus64.out_imm, bus64.out_inst} !== 104'h0) begin errors++; $display("FAIL reset_data got ctl %b imm %h inst %h exp zeros", ctl64, bus64.out_imm, bus64.out_inst); end
    reset = 1'b1;
    #1;
    checks++; if (bus64.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", bus64.in_ready); end
  endtask

  task automatic test_addi();
    bus64.in_valid = 1'b1; bus64.in_inst = 32'hFFF0_0093; bus64.in_pc = 64'h1000;
    bus64.out_ready = 1'b1;
    tick();
    bus64.in_valid = 1'b0;
    checks++; if (bus64.out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got %b exp 1", bus64.out_valid); end
    checks++; if (bus64.out_imm !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL addi_imm got %h exp all ones", bus64.out_imm); end
    checks++; if (bus64.out_rd !== 5'd1 || bus64.out_pc !== 64'h1000) begin errors++; $display("FAIL addi_rd_pc got rd %0d pc %h exp 1 1000", bus64.out_rd, bus64.out_pc); end
    checks++; if (ctl64 !== 8'b1010_0000 || bus64.out_fmt !== FMT_I) begin errors++; $display("FAIL addi_ctl got %b fmt %0d exp 10100000 fmt 1", ctl64, bus64.out_fmt); end
    tick();
    checks++; if (bus64.out_valid !== 1'b0) begin errors++; $display("FAIL addi_drain got %b exp 0", bus64.out_valid); end
  endtask

  task automatic test_store();
    bus64.in_valid = 1'b1; bus64.in_inst = 32'h0020_B423; bus64.in_pc = 64'h1004;
    tick();
    bus64.in_valid = 1'b0;
    checks++; if (bus64.out_imm !== 64'd8) begin errors++; $display("FAIL sd_imm got %h exp 8", bus64.out_imm); end
    checks++; if (bus64.out_rs1 !== 5'd1 || bus64.out_rs2 !== 5'd2) begin errors++; $display("FAIL sd_rs got %0d %0d exp 1 2", bus64.out_rs1, bus64.out_rs2); end
    checks++; if (ctl64 !== 8'b0010_1000 || bus64.out_fmt !== FMT_S) begin errors++; $display("FAIL sd_ctl got %b fmt %0d exp 00101000 fmt 2", ctl64, bus64.out_fmt); end
    tick();
  endtask

  task automatic test_backpressure();
    bus64.in_valid = 1'b1; bus64.in_inst = 32'hFE00_0CE3; bus64.in_pc = 64'h2000;
    bus64.out_ready = 1'b0;
    tick();
    bus64.in_inst = 32'h0010_0113; bus64.in_pc = 64'h2004;
    #1;
    checks++; if (bus64.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b exp 0", bus64.in_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus64.out_valid !== 1'b1 || bus64.out_inst !== 32'hFE00_0CE3 ||
          bus64.out_imm !== 64'hFFFF_FFFF_FFFF_FFF8 || ctl64 !== 8'b0000_0100 ||
          bus64.out_pc !== 64'h2000 || bus64.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d got v %b inst %h imm %h ctl %b rdy %b exp 1 fe000ce3 ..fff8 00000100 0",
                 i, bus64.out_valid, bus64.out_inst, bus64.out_imm, ctl64, bus64.in_ready);
      end
    end
    bus64.out_ready = 1'b1;
    #1;
    checks++; if (bus64.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", bus64.in_ready); end
    tick();
    bus64.in_valid = 1'b0;
    checks++; if (bus64.out_valid !== 1'b1 || bus64.out_inst !== 32'h0010_0113 || bus64.out_imm !== 64'd1) begin errors++; $display("FAIL bp_next got v %b inst %h imm %h exp 1 00100113 1", bus64.out_valid, bus64.out_inst, bus64.out_imm); end
    tick();
    checks++; if (bus64.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", bus64.out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] insts [8];
    logic [63:0] imms  [8];
    logic [7:0]  ctls  [8];
    fmt_e        fmts  [8];
    insts[0] = 32'h1234_52B7; imms[0] = 64'h1234_5000;           ctls[0] = 8'b1010_0000; fmts[0] = FMT_U; // lui
    insts[1] = 32'h0000_0097; imms[1] = 64'h0;                   ctls[1] = 8'b1110_0000; fmts[1] = FMT_U; // auipc
    insts[2] = 32'hFFDF_F0EF; imms[2] = 64'hFFFF_FFFF_FFFF_FFFC; ctls[2] = 8'b1110_0010; fmts[2] = FMT_J; // jal -4
    insts[3] = 32'h0000_8067; imms[3] = 64'h0;                   ctls[3] = 8'b1010_0010; fmts[3] = FMT_I; // jalr
    insts[4] = 32'h0000_B283; imms[4] = 64'h0;                   ctls[4] = 8'b1011_0000; fmts[4] = FMT_I; // ld
    insts[5] = 32'h0020_81B3; imms[5] = 64'h0;                   ctls[5] = 8'b1000_0000; fmts[5] = FMT_R; // add
    insts[6] = 32'h0000_001B; imms[6] = 64'h0;                   ctls[6] = 8'b1010_0000; fmts[6] = FMT_I; // addiw
    insts[7] = 32'hFFFF_FFFF; imms[7] = 64'h0;                   ctls[7] = 8'b0000_0001; fmts[7] = FMT_N; // illegal
    bus64.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus64.in_valid = 1'b1; bus64.in_inst = insts[i]; bus64.in_pc = 64'h3000 + 64'(4 * i);
      tick();
      checks++;
      if (bus64.out_valid !== 1'b1 || bus64.out_inst !== insts[i] || bus64.out_imm !== imms[i] ||
          ctl64 !== ctls[i] || bus64.out_fmt !== fmts[i] || bus64.out_pc !== 64'h3000 + 64'(4 * i)) begin
        errors++;
        $display("FAIL b2b%0d got v %b inst %h imm %h ctl %b fmt %0d exp inst %h imm %h ctl %b fmt %0d",
                 i, bus64.out_valid, bus64.out_inst, bus64.out_imm, ctl64, bus64.out_fmt,
                 insts[i], imms[i], ctls[i], fmts[i]);
      end
    end
    bus64.in_valid = 1'b0;
    tick();
    checks++; if (bus64.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b exp 0", bus64.out_valid); end
  endtask

  task automatic test_flush();
    bus64.in_valid = 1'b1; bus64.in_inst = 32'h0020_81B3; bus64.out_ready = 1'b0;
    tick();
    bus64.in_inst = 32'hFFF0_0093; flush = 1'b1;
    #1;
    checks++; if (bus64.in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b exp 0", bus64.in_ready); end
    bus64.out_ready = 1'b1;
    #1;
    checks++; if (bus64.in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready_consume got %b exp 0", bus64.in_ready); end
    tick();
    flush = 1'b0; bus64.in_valid = 1'b0;
    checks++; if (bus64.out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", bus64.out_valid); end
  endtask

  task automatic test_reset_mid();
    bus64.in_valid = 1'b1; bus64.in_inst = 32'hFFDF_F0EF; bus64.out_ready = 1'b0;
    tick();
    bus64.in_valid = 1'b0; reset = 1'b0;
    tick();
    checks++; if (bus64.out_valid !== 1'b0 || ctl64 !== 8'h00 || bus64.out_fmt !== FMT_N || bus64.out_imm !== 64'h0) begin errors++; $display("FAIL rstmid got v %b ctl %b fmt %0d imm %h exp 0 0 6 0", bus64.out_valid, ctl64, bus64.out_fmt, bus64.out_imm); end
    reset = 1'b1; bus64.out_ready = 1'b1;
  endtask

  task automatic test_halt();
    bus64.in_valid = 1'b1; bus64.in_inst = INST_EBREAK; bus64.out_ready = 1'b1;
    tick();
    bus64.in_valid = 1'b0;
    checks++; if (bus64.out_valid !== 1'b1 || bus64.out_fmt !== FMT_N || ctl64 !== 8'h00 || halted64 !== 1'b0) begin errors++; $display("FAIL ebreak_entry got v %b fmt %0d ctl %b halted %b exp 1 6 0 0", bus64.out_valid, bus64.out_fmt, ctl64, halted64); end
    tick();
    checks++; if (halted64 !== 1'b1) begin errors++; $display("FAIL halt_set got %b exp 1", halted64); end
    bus64.in_valid = 1'b1; bus64.in_inst = 32'hFFF0_0093;
    #1;
    checks++; if (bus64.in_ready !== 1'b0) begin errors++; $display("FAIL halt_in_ready got %b exp 0", bus64.in_ready); end
    tick();
    checks++; if (bus64.out_valid !== 1'b0) begin errors++; $display("FAIL halt_no_accept got %b exp 0", bus64.out_valid); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (halted64 !== 1'b1) begin errors++; $display("FAIL halt_flush got %b exp 1", halted64); end
    bus64.in_valid = 1'b0; reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    checks++; if (halted64 !== 1'b0 || bus64.in_ready !== 1'b1) begin errors++; $display("FAIL halt_reset got halted %b rdy %b exp 0 1", halted64, bus64.in_ready); end
  endtask

  task automatic test_xlen32();
    bus32.out_ready = 1'b1;
    bus32.in_valid = 1'b1; bus32.in_inst = 32'h8000_00B7; bus32.in_pc = 32'h100;
    tick();
    checks++; if (bus32.out_imm !== 32'h8000_0000 || bus32.out_fmt !== FMT_U || ctl32 !== 8'b1010_0000) begin errors++; $display("FAIL x32_lui got imm %h fmt %0d ctl %b exp 80000000 4 10100000", bus32.out_imm, bus32.out_fmt, ctl32); end
    bus32.in_inst = 32'h0000_001B;
    tick();
    bus32.in_valid = 1'b0;
    checks++; if (ctl32 !== 8'b0000_0001 || bus32.out_fmt !== FMT_N) begin errors++; $display("FAIL x32_addiw got ctl %b fmt %0d exp 00000001 6", ctl32, bus32.out_fmt); end
  endtask

  initial begin
    bus64.in_valid = 1'b0; bus64.in_pc = '0; bus64.in_inst = '0; bus64.out_ready = 1'b1;
    bus32.in_valid = 1'b0; bus32.in_pc = '0; bus32.in_inst = '0; bus32.out_ready = 1'b1;
    test_reset();
    test_addi();
    test_store();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_xlen32();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
